module_item_decoder: RTL and testbench

- Receive-side counterpart of the module_item encoder. The encoder drives each output bit as out[g] = (~in ^ ((WIDTH/2) << g))[g].
- This block accepts a framed stream of encoded words and inverts that transform to recover the original words.
- It strips a trailing checksum word from each frame, verifies it, and re-emits the payload with a correct end-of-frame marker.
- It sits between the encoded link and the downstream consumer, with valid/ready on both sides.

---
 rtl/module_item_decoder.sv | 96 +++++++++
 tb/tb_module_item_decoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_item_decoder.sv
// Receive-side decoder for module_item framed streams: inverts the encoder transform,
// strips and verifies the trailing XOR checksum word, and re-emits the payload with dec_last.
module module_item_decoder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_valid,
    output logic             enc_ready,
    input  logic [WIDTH-1:0] enc_data,
    input  logic             enc_last,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [WIDTH-1:0] dec_data,
    output logic             dec_last,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int              HALF    = WIDTH / 2;
    localparam logic [WIDTH-1:0] MASK   = {WIDTH{HALF[0]}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] enc_word;
    logic             accept;
    logic             chk_match;

    assign enc_ready = !dec_valid || dec_ready;
    assign accept    = enc_valid && enc_ready;
    assign enc_word  = ~enc_data ^ MASK;
    // acc is zero whenever we sit in IDLE, so one compare covers empty frames too
    assign chk_match = (enc_word == acc);

    // A held word is released only once the next beat tells us whether it ends the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held      <= '0;
            acc       <= '0;
            dec_valid <= 1'b0;
            dec_data  <= '0;
            dec_last  <= 1'b0;
        end else begin
            if (dec_valid && dec_ready) begin
                dec_valid <= 1'b0;
            end
            if (accept) begin
                if (state == HOLD) begin
                    dec_valid <= 1'b1;
                    dec_data  <= held;
                    dec_last  <= enc_last;
                end
                if (enc_last) begin
                    acc   <= '0;
                    state <= IDLE;
                end else begin
                    held  <= enc_word;
                    acc   <= acc ^ enc_word;
                    state <= HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (accept && enc_last) begin
                frame_ok  <= chk_match;
                frame_err <= !chk_match;
                if (frame_count != CNT_MAX) begin
                    frame_count <= frame_count + 1'b1;
                end
                if (!chk_match && err_count != CNT_MAX) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_module_item_decoder.sv
// Randomized self-checking bench for module_item_decoder: a frame-level model predicts payload,
// dec_last and checksum outcome; a small WIDTH=6/CNT_W=2 instance covers identity decode and saturation.
module tb_module_item_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        enc_valid;
    logic        enc_ready;
    logic [31:0] enc_data;
    logic        enc_last;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_data;
    logic        dec_last;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    logic        e6_valid;
    logic        e6_ready;
    logic [5:0]  e6_data;
    logic        e6_last;
    logic        d6_valid;
    logic        d6_ready;
    logic [5:0]  d6_data;
    logic        d6_last;
    logic        ok6;
    logic        err6;
    logic [1:0]  fc6;
    logic [1:0]  ec6;

    module_item_decoder #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data), .enc_last(enc_last),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data), .dec_last(dec_last),
        .frame_ok(frame_ok), .frame_err(frame_err),
        .frame_count(frame_count), .err_count(err_count)
    );

    module_item_decoder #(.WIDTH(6), .CNT_W(2)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .enc_valid(e6_valid), .enc_ready(e6_ready), .enc_data(e6_data), .enc_last(e6_last),
        .dec_valid(d6_valid), .dec_ready(d6_ready), .dec_data(d6_data), .dec_last(d6_last),
        .frame_ok(ok6), .frame_err(err6),
        .frame_count(fc6), .err_count(ec6)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_data_q[$];
    bit          exp_last_q[$];
    bit          res_q[$];
    logic [31:0] got_q[$];
    bit          got_last_q[$];
    int          ok_seen  = 0;
    int          err_seen = 0;
    int          m_frames = 0;
    int          m_errs   = 0;
    bit          chk_en   = 1'b0;
    int          rdy_mode = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder transform is an involution: both directions are ~x ^ MASK
    function automatic logic [31:0] model_code(input logic [31:0] x, input int w);
        int half;
        half = w / 2;
        return (half % 2 == 1) ? x : ~x;
    endfunction

    // Consumer backpressure: always ready, fixed 1,0,0,1 pattern, or random
    initial begin
        bit pat [4];
        int ph;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph = 0;
        dec_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin dec_ready = pat[ph % 4]; ph++; end
                2:       dec_ready = 1'($urandom_range(0, 1));
                default: dec_ready = 1'b1;
            endcase
        end
    end

    // Single compare process for the 32-bit instance
    bit          pend = 1'b0;
    bit          exp_ok = 1'b1;
    bit          stalled = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (!chk_en) begin
            pend    = 1'b0;
            stalled = 1'b0;
        end else begin
            checkOutput("enc_ready_rule", 64'(enc_ready), 64'(!dec_valid || dec_ready));
            if (stalled) begin
                checkOutput("stall_valid", 64'(dec_valid), 64'(1));
                checkOutput("stall_data", 64'(dec_data), 64'(prev_data));
                checkOutput("stall_last", 64'(dec_last), 64'(prev_last));
            end
            if (dec_valid && dec_ready) begin
                checkOutput("beat_expected", 64'(exp_data_q.size() != 0), 64'(1));
                if (exp_data_q.size() != 0) begin
                    checkOutput("dec_data", 64'(dec_data), 64'(exp_data_q.pop_front()));
                    checkOutput("dec_last", 64'(dec_last), 64'(exp_last_q.pop_front()));
                end
                got_q.push_back(dec_data);
                got_last_q.push_back(dec_last);
            end
            stalled   = dec_valid && !dec_ready;
            prev_data = dec_data;
            prev_last = dec_last;

            ok_seen  += int'(frame_ok);
            err_seen += int'(frame_err);
            if (pend) begin
                checkOutput("frame_ok", 64'(frame_ok), 64'(exp_ok));
                checkOutput("frame_err", 64'(frame_err), 64'(!exp_ok));
                if (m_frames < 65535) m_frames++;
                if (!exp_ok && m_errs < 65535) m_errs++;
            end else begin
                checkOutput("no_pulse", 64'({frame_ok, frame_err}), 64'(0));
            end
            checkOutput("frame_count", 64'(frame_count), 64'(m_frames));
            checkOutput("err_count", 64'(err_count), 64'(m_errs));

            pend = enc_valid && enc_ready && enc_last;
            if (pend) begin
                checkOutput("result_expected", 64'(res_q.size() != 0), 64'(1));
                exp_ok = (res_q.size() != 0) ? res_q.pop_front() : 1'b1;
            end
        end
    end

    task automatic driveBeat(input logic [31:0] d, input bit l);
        bit ok;
        enc_valid = 1'b1;
        enc_data  = d;
        enc_last  = l;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = enc_ready;
            @(posedge clk);
            #1;
        end
        checkOutput("accept_timeout", 64'(ok), 64'(1));
        enc_valid = 1'b0;
    endtask

    // words and chk are decoded values; the model predicts payload order, dec_last and outcome
    task automatic applyStimulus(input logic [31:0] words[$], input logic [31:0] chk, input bit gaps);
        logic [31:0] x;
        x = '0;
        foreach (words[i]) begin
            exp_data_q.push_back(words[i]);
            exp_last_q.push_back(i == words.size() - 1);
            x ^= words[i];
        end
        res_q.push_back(x == chk);
        foreach (words[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            driveBeat(model_code(words[i], 32), 1'b0);
        end
        driveBeat(model_code(chk, 32), 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_data_q.size() != 0 || res_q.size() != 0 || pend) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(n < 1000), 64'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send6(input logic [5:0] d, input bit l);
        bit ok;
        e6_valid = 1'b1;
        e6_data  = d;
        e6_last  = l;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = e6_ready;
            @(posedge clk);
            #1;
        end
        checkOutput("w6_accept_timeout", 64'(ok), 64'(1));
        e6_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] x;
        int          len;
        int          g;

        rst_n     = 1'b0;
        enc_valid = 1'b0;
        enc_data  = '0;
        enc_last  = 1'b0;
        e6_valid  = 1'b0;
        e6_data   = '0;
        e6_last   = 1'b0;
        d6_ready  = 1'b1;
        #3;
        checkOutput("reset_dec_valid", 64'(dec_valid), 64'(0));
        checkOutput("reset_dec_data", 64'(dec_data), 64'(0));
        checkOutput("reset_pulses", 64'({frame_ok, frame_err}), 64'(0));
        checkOutput("reset_counts", 64'({frame_count, err_count}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        $display("[TB] directed frames");
        words = '{32'h1, 32'h2};
        applyStimulus(words, 32'h3, 1'b0);
        drain();
        checkOutput("t1_beats", 64'(got_q.size()), 64'(2));
        checkOutput("t1_word0", 64'(got_q[0]), 64'h1);
        checkOutput("t1_word1", 64'(got_q[1]), 64'h2);
        checkOutput("t1_lasts", 64'({got_last_q[0], got_last_q[1]}), 64'b01);
        checkOutput("t1_ok_pulses", 64'(ok_seen), 64'(1));
        checkOutput("t1_counts", 64'({frame_count, err_count}), 64'h0001_0000);

        applyStimulus(words, 32'h0, 1'b0);
        drain();
        checkOutput("t2_err_pulses", 64'(err_seen), 64'(1));
        checkOutput("t2_word0", 64'(got_q[2]), 64'h1);
        checkOutput("t2_counts", 64'({frame_count, err_count}), 64'h0002_0001);

        words = {};
        applyStimulus(words, 32'h0, 1'b0);
        drain();
        checkOutput("t3_no_beats", 64'(got_q.size()), 64'(4));
        checkOutput("t3_ok_pulses", 64'(ok_seen), 64'(2));

        $display("[TB] backpressure pattern, back-to-back frames");
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            words = {};
            x = '0;
            for (int i = 0; i < 6; i++) begin
                words.push_back($urandom);
                x ^= words[i];
            end
            applyStimulus(words, (f == 1) ? (x ^ 32'h80) : x, 1'b0);
        end
        drain();

        $display("[TB] random frames");
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            words = {};
            x = '0;
            len = $urandom_range(0, 8);
            for (int i = 0; i < len; i++) begin
                words.push_back($urandom);
                x ^= words[i];
            end
            if ($urandom_range(0, 9) < 3) x ^= ($urandom | 32'h1);
            applyStimulus(words, x, 1'b1);
        end
        drain();
        rdy_mode = 0;

        $display("[TB] WIDTH=6 instance");
        send6(6'h15, 1'b0);
        send6(6'h2A, 1'b1);
        @(negedge clk);
        checkOutput("w6_a_valid", 64'(d6_valid), 64'(1));
        checkOutput("w6_a_data", 64'(d6_data), 64'h15);
        checkOutput("w6_a_last", 64'(d6_last), 64'(1));
        checkOutput("w6_a_pulses", 64'({ok6, err6}), 64'b01);
        checkOutput("w6_a_counts", 64'({fc6, ec6}), 64'b0101);
        @(posedge clk);
        #1;
        send6(6'h05, 1'b0);
        send6(6'h05, 1'b1);
        @(negedge clk);
        checkOutput("w6_b_data", 64'(d6_data), 64'h05);
        checkOutput("w6_b_last", 64'(d6_last), 64'(1));
        checkOutput("w6_b_pulses", 64'({ok6, err6}), 64'b10);
        checkOutput("w6_b_counts", 64'({fc6, ec6}), 64'b1001);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send6(6'h01, 1'b0);
            send6(6'h00, 1'b1);
            @(negedge clk);
            checkOutput("w6_sat_pulse", 64'({ok6, err6}), 64'b01);
            g = (3 + i < 3) ? 3 + i : 3;
            checkOutput("w6_sat_frames", 64'(fc6), 64'(g));
            g = (2 + i < 3) ? 2 + i : 3;
            checkOutput("w6_sat_errs", 64'(ec6), 64'(g));
            @(posedge clk);
            #1;
        end

        $display("[TB] reset mid-frame");
        chk_en = 1'b0;
        driveBeat(32'hFFFF_FFEE, 1'b0);
        driveBeat(32'hFFFF_FFDD, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dec_valid", 64'(dec_valid), 64'(0));
        checkOutput("midrst_dec_data", 64'(dec_data), 64'(0));
        checkOutput("midrst_dec_last", 64'(dec_last), 64'(0));
        checkOutput("midrst_pulses", 64'({frame_ok, frame_err}), 64'(0));
        checkOutput("midrst_counts", 64'({frame_count, err_count}), 64'(0));
        exp_data_q.delete();
        exp_last_q.delete();
        res_q.delete();
        got_q.delete();
        got_last_q.delete();
        m_frames = 0;
        m_errs   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        words = '{32'hA5, 32'h5A, 32'h1234};
        applyStimulus(words, 32'hA5 ^ 32'h5A ^ 32'h1234, 1'b0);
        drain();
        checkOutput("post_rst_beats", 64'(got_q.size()), 64'(3));
        checkOutput("post_rst_word0", 64'(got_q[0]), 64'hA5);
        checkOutput("post_rst_word2", 64'(got_q[2]), 64'h1234);
        checkOutput("post_rst_counts", 64'({frame_count, err_count}), 64'h0001_0000);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
